byte_word_assembler: RTL and testbench
======================================

Name: byte_word_assembler

Overview:
- Upstream feeder for the sha_output serial-to-parallel word register.
- Accepts a byte stream over a valid/ready handshake and packs bytes big-endian into 32-bit words.
- Presents each completed word on word_out with a one-cycle shift_enable strobe.
- After NUM_WORDS words, flags frame_done and stalls input until the consumer acknowledges that it has read the parallel hash.

Parameters:
- NUM_WORDS, 8, words per frame; must match the downstream register depth; legal range 1..255.
- TIMEOUT_CYCLES, 1024, idle cycles before a partial frame is abandoned; used only when the optional feature is compiled in; legal range 2..65535.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- byte_in  input  8  incoming data byte.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  block can accept a byte this cycle.
- word_out  output  32  assembled word; drives the downstream serial_in.
- shift_enable  output  1  one-cycle strobe; word_out is valid and must be shifted in.
- frame_done  output  1  level; NUM_WORDS words have been shifted since the last frame start.
- frame_ack  input  1  consumer has read the parallel output; releases frame_done.
- word_count  output  $clog2(NUM_WORDS+1)  words shifted in the current frame.
- timeout_err  output  1  one-cycle pulse; a partial frame was discarded.

Behaviour:
- Reset: one clock and one synchronous active-high reset; rst is sampled only on the rising edge of clk.
- Reset values, held while rst=1: state=COLLECT, byte_idx=0, word_count=0, word_out=0, shift_enable=0, frame_done=0, timeout_err=0, byte_ready=0.
- byte_ready=1 in the first cycle after rst deasserts.
- Reset mid-frame discards all partial bytes and words.
- Byte accept: a transfer occurs when byte_valid && byte_ready.
- Byte placement by byte_idx: 0 -> word_out[31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0].
- byte_idx increments on each accepted byte and wraps 3 -> 0.
- State COLLECT:
  - byte_ready = 1.
  - Accepting the byte at byte_idx=3 in cycle t moves to SHIFT.
- State SHIFT (exactly one cycle, t+1):
  - shift_enable = 1; word_out holds the complete word; byte_ready = 0.
  - word_count increments at the end of this cycle.
  - If the incremented count equals NUM_WORDS, go to DONE; otherwise return to COLLECT.
- State DONE:
  - frame_done = 1; byte_ready = 0; shift_enable = 0.
  - word_out holds the last word.
  - frame_ack=1 moves to COLLECT with word_count=0 and byte_idx=0; frame_done is 0 the next cycle.
- Latency:
  - Final byte accepted at cycle t.
  - shift_enable at t+1.
  - frame_done first high at t+2.
- frame_ack outside DONE is ignored.
- frame_ack arriving together with the final shift is ignored; the consumer must ack after frame_done is seen.
- byte_valid while byte_ready=0 is ignored. The source must hold byte_in/byte_valid until accepted; the block does not latch un-accepted bytes.
- word_out changes only when a byte is accepted or on reset.
- Throughput: at most one word per 5 cycles, i.e. 4 byte cycles plus 1 SHIFT cycle.
- NUM_WORDS=1: every word produces DONE.

Optional Feature:
- Macro: BYTE_WORD_ASM_TIMEOUT_EN.
- Defined:
  - A 16-bit idle counter runs in COLLECT whenever a frame is partial (byte_idx!=0 or word_count!=0).
  - The counter clears on any accepted byte and whenever the frame is not partial.
  - On reaching TIMEOUT_CYCLES: byte_idx=0, word_count=0, timeout_err pulses for 1 cycle, and the state stays COLLECT.
  - Words already shifted downstream are not cleared; the next full frame overwrites them.
- Undefined:
  - No counter is built; timeout_err is tied to 0.
  - Partial frames wait indefinitely.

Test Plan:
- Reset, then bytes DE AD BE EF with byte_valid continuous -> shift_enable one cycle after EF accepted, word_out=32'hDEADBEEF, word_count=1, byte_ready=0 in that cycle only.
- 32 bytes 00..1F back-to-back -> 8 shift_enable pulses with words 00010203 ... 1C1D1E1F, frame_done=1 two cycles after byte 1F, byte_ready=0 until frame_ack.
- In DONE, hold byte_valid=1 for 10 cycles, then frame_ack=1 -> no bytes accepted or shifted during the 10 cycles; next cycle frame_done=0, word_count=0, byte_ready=1.
- Assert rst after 6 bytes of a frame -> all outputs at reset values; next bytes 11 22 33 44 produce word_out=32'h11223344, word_count=1.
- frame_ack=1 while in COLLECT with word_count=3 -> no effect; word_count stays 3.
- BYTE_WORD_ASM_TIMEOUT_EN with TIMEOUT_CYCLES=16: send 2 bytes, then idle 16 cycles -> timeout_err single pulse, byte_idx=0, word_count=0; next 4 bytes A1 B2 C3 D4 give word_out=32'hA1B2C3D4. Without the macro: no pulse, and the next 2 bytes complete the original word.

Source files
------------

// File: rtl/byte_word_assembler_if.sv
// Byte-stream in / word-stream out bundle for byte_word_assembler.
// master = byte source and word consumer, slave = the assembler.
interface byte_word_assembler_if #(
  parameter int NUM_WORDS = 8
);
  localparam int CW = $clog2(NUM_WORDS + 1);

  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic [31:0]   word_out;
  logic          shift_enable;
  logic          frame_done;
  logic          frame_ack;
  logic [CW-1:0] word_count;
  logic          timeout_err;

  modport master (
    output byte_in, byte_valid, frame_ack,
    input  byte_ready, word_out, shift_enable, frame_done, word_count, timeout_err
  );

  modport slave (
    input  byte_in, byte_valid, frame_ack,
    output byte_ready, word_out, shift_enable, frame_done, word_count, timeout_err
  );
endinterface

// File: rtl/byte_word_assembler.sv
// Packs a valid/ready byte stream big-endian into 32-bit words for the downstream shift register.
// Optional idle timeout for partial frames is built when BYTE_WORD_ASM_TIMEOUT_EN is defined.
module byte_word_assembler #(
  parameter int NUM_WORDS      = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                  clk,
  input logic                  rst,
  byte_word_assembler_if.slave bus
);
  localparam int CW = $clog2(NUM_WORDS + 1);

  localparam logic [1:0] S_COLLECT = 2'd0;
  localparam logic [1:0] S_SHIFT   = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_WORDS - 1);

  logic [1:0]    r_state;
  logic [1:0]    r_byte_idx;
  logic [CW-1:0] r_word_count;
  logic [31:0]   r_word_out;
  logic          r_timeout_err;
  logic          w_accept;
  logic          w_timeout;

  // Ready is gated by rst so it reads 0 throughout reset and 1 the first cycle after.
  assign bus.byte_ready   = (r_state == S_COLLECT) && !rst;
  assign bus.shift_enable = (r_state == S_SHIFT);
  assign bus.frame_done   = (r_state == S_DONE);
  assign bus.word_out     = r_word_out;
  assign bus.word_count   = r_word_count;
  assign bus.timeout_err  = r_timeout_err;

  assign w_accept = bus.byte_valid && bus.byte_ready;

`ifdef BYTE_WORD_ASM_TIMEOUT_EN
  logic [15:0] r_idle_cnt;
  logic        w_partial;

  assign w_partial = (r_byte_idx != 2'd0) || (r_word_count != '0);
  assign w_timeout = (r_state == S_COLLECT) && w_partial && !w_accept &&
                     (r_idle_cnt == 16'(TIMEOUT_CYCLES - 1));

  // Idle counter: runs only while a partial frame sits in COLLECT with no byte arriving.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idle_cnt <= 16'd0;
    end else if ((r_state != S_COLLECT) || !w_partial || w_accept || w_timeout) begin
      r_idle_cnt <= 16'd0;
    end else begin
      r_idle_cnt <= r_idle_cnt + 16'd1;
    end
  end
`else
  logic w_unused_timeout;

  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_timeout        = 1'b0;
`endif

  // Frame FSM together with the byte lane, word counter and timeout pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_COLLECT;
      r_byte_idx    <= 2'd0;
      r_word_count  <= '0;
      r_word_out    <= 32'd0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_timeout;
      case (r_state)
        S_COLLECT: begin
          if (w_timeout) begin
            r_byte_idx   <= 2'd0;
            r_word_count <= '0;
          end else if (w_accept) begin
            case (r_byte_idx)
              2'd0:    r_word_out[31:24] <= bus.byte_in;
              2'd1:    r_word_out[23:16] <= bus.byte_in;
              2'd2:    r_word_out[15:8]  <= bus.byte_in;
              2'd3:    r_word_out[7:0]   <= bus.byte_in;
              default: r_word_out        <= r_word_out;
            endcase
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
              r_state <= S_SHIFT;
            end else begin
              r_state <= S_COLLECT;
            end
          end else begin
            r_state <= S_COLLECT;
          end
        end
        S_SHIFT: begin
          // frame_ack is deliberately not looked at here; it only counts once DONE is visible.
          r_word_count <= r_word_count + CW'(1);
          if (r_word_count == LAST_IDX) begin
            r_state <= S_DONE;
          end else begin
            r_state <= S_COLLECT;
          end
        end
        S_DONE: begin
          if (bus.frame_ack) begin
            r_state      <= S_COLLECT;
            r_word_count <= '0;
            r_byte_idx   <= 2'd0;
          end else begin
            r_state <= S_DONE;
          end
        end
        default: begin
          r_state      <= S_COLLECT;
          r_byte_idx   <= 2'd0;
          r_word_count <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_byte_word_assembler.sv
// Directed scoreboard bench for byte_word_assembler (NUM_WORDS=8, TIMEOUT_CYCLES=16).
module tb_byte_word_assembler;
  localparam int NW = 8;
  localparam int TO = 16;

  typedef struct packed {
    logic [31:0] w;
    logic [3:0]  c;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  byte_word_assembler_if #(.NUM_WORDS(NW)) bus ();

  byte_word_assembler #(.NUM_WORDS(NW), .TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_acc    = 0;
  int   n_shift  = 0;
  int   n_to     = 0;
  exp_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit done = 1'b0;
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = bus.byte_ready;
      tick();
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: byte %h not accepted within 50 cycles", b);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input logic [3:0] c);
    q.push_back({w, c});
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  // Monitor: scores every shift_enable strobe against the expected-word queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.byte_valid && bus.byte_ready) n_acc++;
        if (bus.timeout_err) n_to++;
        if (bus.shift_enable) begin
          n_shift++;
          if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_shift: got word %h, expected no shift", bus.word_out);
          end else begin
            e = q.pop_front();
            chk("shift_word", bus.word_out, e.w);
            chk("shift_count", 32'(bus.word_count), 32'(e.c));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    int sh0;
    int to0;

    rst            = 1'b1;
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;
    bus.frame_ack  = 1'b0;
    repeat (3) tick();

    // Reset values
    @(negedge clk);
    chk("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
    chk("rst_shift_enable", 32'(bus.shift_enable), 32'd0);
    chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
    chk("rst_word_count", 32'(bus.word_count), 32'd0);
    chk("rst_word_out", bus.word_out, 32'h0);
    chk("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(bus.byte_ready), 32'd1);

    // DE AD BE EF back-to-back
    tick();
    send_word(32'hDEADBEEF, 4'd0);
    bus.byte_valid = 1'b0;
    @(negedge clk);
    chk("t1_shift_enable", 32'(bus.shift_enable), 32'd1);
    chk("t1_ready_low", 32'(bus.byte_ready), 32'd0);
    chk("t1_word_out", bus.word_out, 32'hDEADBEEF);
    tick();
    @(negedge clk);
    chk("t1_word_count", 32'(bus.word_count), 32'd1);
    chk("t1_ready_back", 32'(bus.byte_ready), 32'd1);
    chk("t1_shift_off", 32'(bus.shift_enable), 32'd0);

    // frame_ack in COLLECT with word_count=3 is ignored
    tick();
    send_word(32'hCAFEBABE, 4'd1);
    send_word(32'h12345678, 4'd2);
    bus.byte_valid = 1'b0;
    tick();
    bus.frame_ack = 1'b1;
    tick();
    tick();
    bus.frame_ack = 1'b0;
    @(negedge clk);
    chk("ack_collect_count", 32'(bus.word_count), 32'd3);
    chk("ack_collect_done", 32'(bus.frame_done), 32'd0);
    chk("ack_collect_ready", 32'(bus.byte_ready), 32'd1);

    // Reset mid-frame after 6 bytes
    tick();
    send_word(32'hA0A1A2A3, 4'd3);
    send_byte(8'hB0);
    send_byte(8'hB1);
    bus.byte_valid = 1'b0;
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("midrst_word_count", 32'(bus.word_count), 32'd0);
    chk("midrst_word_out", bus.word_out, 32'h0);
    chk("midrst_byte_ready", 32'(bus.byte_ready), 32'd0);
    chk("midrst_frame_done", 32'(bus.frame_done), 32'd0);
    tick();
    rst = 1'b0;
    send_word(32'h11223344, 4'd0);
    bus.byte_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("midrst_new_count", 32'(bus.word_count), 32'd1);
    chk("midrst_new_word", bus.word_out, 32'h11223344);

    // Partial word followed by a long idle
    tick();
    to0 = n_to;
    send_byte(8'hA1);
    send_byte(8'hB2);
    bus.byte_valid = 1'b0;
    repeat (20) tick();
`ifdef BYTE_WORD_ASM_TIMEOUT_EN
    chk("timeout_pulses", 32'(n_to - to0), 32'd1);
    chk("timeout_count", 32'(bus.word_count), 32'd0);
    send_word(32'hA1B2C3D4, 4'd0);
    bus.byte_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("timeout_next_count", 32'(bus.word_count), 32'd1);
`else
    chk("timeout_pulses", 32'(n_to - to0), 32'd0);
    chk("timeout_count", 32'(bus.word_count), 32'd1);
    q.push_back({32'hA1B2C3D4, 4'd1});
    send_byte(8'hC3);
    send_byte(8'hD4);
    bus.byte_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("timeout_next_count", 32'(bus.word_count), 32'd2);
`endif
    chk("timeout_word", bus.word_out, 32'hA1B2C3D4);

    // Full frame of bytes 00..1F
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int w = 0; w < NW; w++) begin
      q.push_back({8'(4 * w), 8'(4 * w + 1), 8'(4 * w + 2), 8'(4 * w + 3), 4'(w)});
      for (int k = 0; k < 4; k++) begin
        send_byte(8'(4 * w + k));
      end
    end
    bus.byte_valid = 1'b0;
    @(negedge clk);
    chk("frame_last_shift", 32'(bus.shift_enable), 32'd1);
    chk("frame_done_early", 32'(bus.frame_done), 32'd0);
    tick();
    @(negedge clk);
    chk("frame_done", 32'(bus.frame_done), 32'd1);
    chk("frame_ready_low", 32'(bus.byte_ready), 32'd0);
    chk("frame_word_count", 32'(bus.word_count), 32'd8);
    chk("frame_shift_off", 32'(bus.shift_enable), 32'd0);

    // DONE stalls input for 10 cycles, then frame_ack releases it
    tick();
    acc0           = n_acc;
    sh0            = n_shift;
    bus.byte_in    = 8'h55;
    bus.byte_valid = 1'b1;
    repeat (10) tick();
    chk("done_no_accept", 32'(n_acc - acc0), 32'd0);
    chk("done_no_shift", 32'(n_shift - sh0), 32'd0);
    chk("done_held", 32'(bus.frame_done), 32'd1);
    chk("done_word_held", bus.word_out, 32'h1C1D1E1F);
    bus.byte_valid = 1'b0;
    bus.frame_ack  = 1'b1;
    tick();
    bus.frame_ack = 1'b0;
    @(negedge clk);
    chk("ack_frame_done", 32'(bus.frame_done), 32'd0);
    chk("ack_word_count", 32'(bus.word_count), 32'd0);
    chk("ack_byte_ready", 32'(bus.byte_ready), 32'd1);

    tick();
    tick();
    chk("queue_empty", 32'(q.size()), 32'd0);
    chk("total_shifts", 32'(n_shift), 32'd14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
